// File: rtl/traffic_pkg.sv
// Shared types, default timings and light decoding for the intersection phase controller.
package traffic_pkg;

    typedef enum logic [1:0] {
        PhUpdown = 2'd0,
        PhTurn   = 2'd1,
        PhPed    = 2'd2
    } phase_e;

    typedef enum logic [1:0] {
        StAllRed = 2'd0,
        StGreen  = 2'd1,
        StClear  = 2'd2
    } ctrl_state_e;

    localparam int unsigned DEF_MIN_GREEN    = 8;
    localparam int unsigned DEF_MAX_GREEN    = 32;
    localparam int unsigned DEF_PED_TIME     = 10;
    localparam int unsigned DEF_AMBER_TIME   = 3;
    localparam int unsigned DEF_ALL_RED_TIME = 2;
    localparam int unsigned DEF_CNT_W        = 8;

    typedef struct packed {
        logic up_green;
        logic down_green;
        logic turn_green;
        logic pedestrian_green;
        logic up_amber;
        logic down_amber;
        logic turn_amber;
        logic pedestrian_flash;
    } lights_t;

    // Light pattern for a controller state and the phase group it is serving.
    function automatic lights_t lights_for(ctrl_state_e st, phase_e ph);
        lights_t l;
        l = '0;
        if (st == StGreen) begin
            unique case (ph)
                PhUpdown: begin
                    l.up_green   = 1'b1;
                    l.down_green = 1'b1;
                end
                PhTurn:  l.turn_green       = 1'b1;
                PhPed:   l.pedestrian_green = 1'b1;
                default: l = '0;
            endcase
        end else if (st == StClear) begin
            unique case (ph)
                PhUpdown: begin
                    l.up_amber   = 1'b1;
                    l.down_amber = 1'b1;
                end
                PhTurn:  l.turn_amber       = 1'b1;
                PhPed:   l.pedestrian_flash = 1'b1;
                default: l = '0;
            endcase
        end
        return l;
    endfunction

    function automatic phase_e phase_succ(phase_e ph);
        unique case (ph)
            PhUpdown: return PhTurn;
            PhTurn:   return PhPed;
            default:  return PhUpdown;
        endcase
    endfunction

    // Round-robin after cur, the current phase itself last; UPDOWN when nobody asks.
    function automatic phase_e pick_next(phase_e cur, logic [2:0] demand);
        phase_e c1;
        phase_e c2;
        c1 = phase_succ(cur);
        c2 = phase_succ(c1);
        if (demand[c1]) return c1;
        if (demand[c2]) return c2;
        if (demand[cur]) return cur;
        return PhUpdown;
    endfunction

endpackage

// File: rtl/phase_timer.sv
// Interval down-counter plus saturating elapsed-green counter.
module phase_timer
    import traffic_pkg::*;
#(
    parameter int unsigned CNT_W       = DEF_CNT_W,
    parameter int unsigned MAX_GREEN   = DEF_MAX_GREEN,
    parameter int unsigned RESET_VALUE = DEF_ALL_RED_TIME
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_value,
    input  logic             elapsed_start,
    output logic             done,
    output logic [CNT_W-1:0] elapsed
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] elapsed_q;

    // Interval counter: load on state entry, the state ends on the cycle it reads 1.
    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= CNT_W'(RESET_VALUE);
        end else if (load) begin
            count_q <= load_value;
        end else if (count_q != '0) begin
            count_q <= count_q - CNT_W'(1);
        end
    end

    // Green cycles so far, counting the entry cycle as 1; parks at MAX_GREEN during rest.
    always_ff @(posedge clock) begin
        if (reset) begin
            elapsed_q <= '0;
        end else if (elapsed_start) begin
            elapsed_q <= CNT_W'(1);
        end else if (elapsed_q < CNT_W'(MAX_GREEN)) begin
            elapsed_q <= elapsed_q + CNT_W'(1);
        end
    end

    assign done    = (count_q == CNT_W'(1));
    assign elapsed = elapsed_q;

endmodule

// File: rtl/signal_phase_ctrl.sv
// Intersection phase controller: sequences UPDOWN, TURN and PED through
// green, clearance and all-red intervals with registered light outputs.
module signal_phase_ctrl
    import traffic_pkg::*;
#(
    parameter int unsigned MIN_GREEN    = DEF_MIN_GREEN,
    parameter int unsigned MAX_GREEN    = DEF_MAX_GREEN,
    parameter int unsigned PED_TIME     = DEF_PED_TIME,
    parameter int unsigned AMBER_TIME   = DEF_AMBER_TIME,
    parameter int unsigned ALL_RED_TIME = DEF_ALL_RED_TIME,
    parameter int unsigned CNT_W        = DEF_CNT_W
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ped_request,
    input  logic       up_sensor,
    input  logic       down_sensor,
    input  logic       turn_sensor,
    output logic       up_green,
    output logic       down_green,
    output logic       turn_green,
    output logic       pedestrian_green,
    output logic       up_amber,
    output logic       down_amber,
    output logic       turn_amber,
    output logic       pedestrian_flash,
    output logic [1:0] phase
);

    ctrl_state_e      state_q, state_d;
    phase_e           phase_q, phase_d;
    phase_e           next_phase_q, next_phase_d;
    logic             ped_pending_q, ped_pending_d;
    lights_t          lights_q;

    logic             timer_load;
    logic [CNT_W-1:0] timer_value;
    logic             elapsed_start;
    logic             timer_done;
    logic [CNT_W-1:0] elapsed;

    logic [2:0]       demand;
    logic [2:0]       own_mask;
    logic             rival_demand;
    logic             green_done;

    phase_timer #(
        .CNT_W       (CNT_W),
        .MAX_GREEN   (MAX_GREEN),
        .RESET_VALUE (ALL_RED_TIME)
    ) u_timer (
        .clock         (clock),
        .reset         (reset),
        .load          (timer_load),
        .load_value    (timer_value),
        .elapsed_start (elapsed_start),
        .done          (timer_done),
        .elapsed       (elapsed)
    );

    assign demand       = {ped_pending_q, turn_sensor, up_sensor | down_sensor};
    assign own_mask     = 3'b001 << phase_q;
    assign rival_demand = |(demand & ~own_mask);

    // PED green is fixed length; vehicle greens yield only to a rival after MIN_GREEN.
    always_comb begin
        if (phase_q == PhPed) begin
            green_done = timer_done;
        end else begin
            green_done = (elapsed >= CNT_W'(MIN_GREEN)) && rival_demand &&
                         (!(|(demand & own_mask)) || (elapsed >= CNT_W'(MAX_GREEN)));
        end
    end

    // Next-state, timer strobes and pedestrian latch.
    always_comb begin
        state_d       = state_q;
        phase_d       = phase_q;
        next_phase_d  = next_phase_q;
        ped_pending_d = ped_pending_q | ped_request;
        timer_load    = 1'b0;
        timer_value   = '0;
        elapsed_start = 1'b0;
        unique case (state_q)
            StAllRed: begin
                if (timer_done) begin
                    state_d       = StGreen;
                    phase_d       = next_phase_q;
                    elapsed_start = 1'b1;
                    timer_load    = 1'b1;
                    timer_value   = CNT_W'(PED_TIME);
                    // A request sampled on the same edge waits for the next round.
                    if (next_phase_q == PhPed) ped_pending_d = ped_request;
                end
            end
            StGreen: begin
                if (green_done) begin
                    state_d      = StClear;
                    next_phase_d = pick_next(phase_q, demand);
                    timer_load   = 1'b1;
                    timer_value  = CNT_W'(AMBER_TIME);
                end
            end
            StClear: begin
                if (timer_done) begin
                    state_d     = StAllRed;
                    timer_load  = 1'b1;
                    timer_value = CNT_W'(ALL_RED_TIME);
                end
            end
            default: state_d = StAllRed;
        endcase
    end

    // Controller state and registered lights.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= StAllRed;
            phase_q       <= PhUpdown;
            next_phase_q  <= PhUpdown;
            ped_pending_q <= 1'b0;
            lights_q      <= '0;
        end else begin
            state_q       <= state_d;
            phase_q       <= phase_d;
            next_phase_q  <= next_phase_d;
            ped_pending_q <= ped_pending_d;
            lights_q      <= lights_for(state_d, phase_d);
        end
    end

    assign up_green         = lights_q.up_green;
    assign down_green       = lights_q.down_green;
    assign turn_green       = lights_q.turn_green;
    assign pedestrian_green = lights_q.pedestrian_green;
    assign up_amber         = lights_q.up_amber;
    assign down_amber       = lights_q.down_amber;
    assign turn_amber       = lights_q.turn_amber;
    assign pedestrian_flash = lights_q.pedestrian_flash;
    assign phase            = phase_q;

endmodule

// File: doc/signal_phase_ctrl.md
Name: signal_phase_ctrl

Overview:
Phase controller that drives the intersection's light outputs: pedestrian_green, up_green, down_green and turn_green. It takes pedestrian push-button pulses and vehicle presence sensors as inputs. It sequences the three conflicting phase groups (UPDOWN, TURN, PED) through green, clearance and all-red intervals. Its outputs are the signals the bound property checkers observe.

Parameters:
MIN_GREEN, 8, minimum green cycles for UPDOWN and TURN
MAX_GREEN, 32, maximum green cycles under conflicting demand
PED_TIME, 10, pedestrian green cycles (fixed)
AMBER_TIME, 3, clearance cycles (vehicle amber / pedestrian flash)
ALL_RED_TIME, 2, all-red cycles between phases and after reset
CNT_W, 8, timer width; all time parameters must fit in it and be >= 1; MIN_GREEN <= MAX_GREEN

Ports:
clock  input  1  system clock
reset  input  1  synchronous, active-high reset
ped_request  input  1  button pulse; latched until served
up_sensor  input  1  level; up-direction vehicle present
down_sensor  input  1  level; down-direction vehicle present
turn_sensor  input  1  level; turn-lane vehicle present
up_green  output  1  up straight green
down_green  output  1  down straight green
turn_green  output  1  turn arrow green
pedestrian_green  output  1  walk
up_amber  output  1  up clearance
down_amber  output  1  down clearance
turn_amber  output  1  turn clearance
pedestrian_flash  output  1  pedestrian clearance
phase  output  2  current phase group: 0=UPDOWN, 1=TURN, 2=PED

Behaviour:
- Clock and reset: one clock, clock. reset is synchronous and active-high.
- All outputs are registered.
- Reset: state ALL_RED, timer=ALL_RED_TIME, next_phase=UPDOWN, ped_pending=0, phase=0, all green/amber/flash outputs 0.
- States: ALL_RED -> GREEN -> CLEAR -> ALL_RED.
- Each state lasts exactly its programmed cycle count. Timer loads on entry and the state exits when the timer hits 1.
- Demand:
  - UPDOWN = up_sensor|down_sensor.
  - TURN = turn_sensor.
  - PED = ped_pending.
- ped_pending:
  - Set the cycle after ped_request is sampled high.
  - Cleared on entry to PED GREEN.
  - A request during PED GREEN or CLEAR re-latches it.
- GREEN UPDOWN: up_green=down_green=1.
- GREEN TURN: turn_green=1.
- GREEN PED: pedestrian_green=1, lasting exactly PED_TIME cycles.
- CLEAR: the matching amber, or pedestrian_flash for PED, for AMBER_TIME cycles.
- UPDOWN/TURN green termination is evaluated each cycle once elapsed >= MIN_GREEN:
  - Requires some other phase to have demand.
  - And either own demand is 0, or elapsed >= MAX_GREEN.
  - CLEAR starts the next cycle.
- Rest: with no competing demand, UPDOWN/TURN green holds indefinitely.
  - elapsed saturates at MAX_GREEN; no wrap.
- Next-phase selection, at CLEAR entry: round-robin UPDOWN -> TURN -> PED -> UPDOWN, skipping phases without demand.
  - If none has demand, UPDOWN is selected.
  - phase updates on GREEN entry.
- Invariants:
  - At most one phase group has any green/amber/flash asserted.
  - turn_green is never asserted with up_green, down_green or pedestrian_green.
  - Every green is followed by its clearance and then ALL_RED_TIME cycles of all-off before any other green.
- Reset mid-operation: all lights off the next cycle; re-enter ALL_RED; pending requests dropped.
- Simultaneous ped_request and PED GREEN entry: pending is set again; that request is served next round.

Decomposition:
- Shared package traffic_pkg:
  - phase_e (UPDOWN, TURN, PED)
  - ctrl_state_e (ALL_RED, GREEN, CLEAR)
  - default timing localparams
  - phase-to-light decode function
- Sub-module phase_timer:
  - CNT_W down-counter with load value/load strobe and done output.
  - Plus the saturating elapsed-green counter.

Test Plan:
- Reset, no demand -> cycles 0-1 all off, phase=0; cycle 2 onward up_green=down_green=1; holds for 100 cycles.
- From rest, ped_request pulse at cycle 20, sensors low -> ped_pending at 21; up/down amber 22-24; all-red 25-26; pedestrian_green 27-36; pedestrian_flash 37-39; all-red 40-41; up_green at 42.
- up_sensor held high, turn_sensor high from cycle 5 -> UPDOWN green lasts MAX_GREEN=32 cycles (2-33); amber 34-36; all-red 37-38; turn_green from 39.
- turn_sensor and ped_request both raised while UPDOWN green -> TURN served before PED (round-robin). Check ordering and that no overlap ever occurs.
- reset asserted mid turn_green -> all outputs 0 the next cycle; ALL_RED for 2 cycles; UPDOWN green after; earlier ped_pending not served.
- Formal/random: sensors and requests random for 10k cycles -> mutual-exclusion and clearance invariants never violated; every ped_request served within one full round.
